// File: rtl/pu_sequencer_if.sv
// pu_sequencer_if: groups the job-control, operand-buffer, processing-unit
// and output-FIFO signals of the sequencer.
//   start/num_windows : job request (environment -> sequencer)
//   rd_en/rd_addr     : operand-buffer read (sequencer -> buffer)
//   pu_en/pu_result   : unit register enable and result
//   out_valid/out_data/out_ready : result stream handshake
//   busy/done         : job status
// master = sequencer side, slave = environment side.
interface pu_sequencer_if #(
  parameter int ADDR_W = 4
);
  logic              start;
  logic [ADDR_W-1:0] num_windows;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              pu_en;
  logic [4:0]        pu_result;
  logic              out_valid;
  logic [4:0]        out_data;
  logic              out_ready;
  logic              busy;
  logic              done;

  modport master (
    input  start, num_windows, pu_result, out_ready,
    output rd_en, rd_addr, pu_en, out_valid, out_data, busy, done
  );

  modport slave (
    output start, num_windows, pu_result, out_ready,
    input  rd_en, rd_addr, pu_en, out_valid, out_data, busy, done
  );
endinterface

// File: rtl/pu_sequencer.sv
// pu_sequencer: runs the 4-lane multiply/add-tree unit over a job of
// num_windows windows. Each issue reads one operand word, enables the unit's
// registers one cycle later, follows the result through the unit's fixed
// pipeline and captures it into an output FIFO. Issue is credit-gated so the
// non-stallable unit can never overrun the FIFO.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset (aborts job, flushes FIFO)
//   bus  : pu_sequencer_if.master (job control, buffer read, unit enable /
//          result, result stream, busy/done)
module pu_sequencer #(
  parameter int ADDR_W     = 4,
  parameter int PIPE_LAT   = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  pu_sequencer_if.master bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + PIPE_LAT + 2) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] n_q, n_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              issue;

  logic              pu_en_q;
  logic [PIPE_LAT-1:0] vld_q, vld_d;

  logic [4:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;
  logic [CNT_W-1:0]  inflight;
  logic              issue_ok;
  logic              push, pop;

  // Results already committed to arrive: the rd_en delay stage plus every
  // set bit of the valid pipeline. Each of them needs a FIFO slot.
  always_comb begin
    inflight = CNT_W'(pu_en_q);
    for (int i = 0; i < PIPE_LAT; i++) begin
      inflight = inflight + CNT_W'(vld_q[i]);
    end
  end

  assign issue_ok = (fifo_cnt_q + inflight) < CNT_W'(FIFO_DEPTH);

  // Next-state / issue decision
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    issue   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.num_windows != '0) begin
            n_d     = bus.num_windows;
            cnt_d   = '0;
            state_d = S_RUN;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (issue_ok) begin
          issue  = 1'b1;
          addr_d = cnt_q;
          cnt_d  = cnt_q + ADDR_W'(1);
          if (cnt_q == n_q - ADDR_W'(1)) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (inflight == '0 && fifo_cnt_q == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Valid pipeline mirrors the unit's product register + adder stages
  always_comb begin
    vld_d    = '0;
    vld_d[0] = pu_en_q;
    for (int i = 1; i < PIPE_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
    end
  end

  assign push = vld_q[PIPE_LAT-1];
  assign pop  = (fifo_cnt_q != '0) && bus.out_ready;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      cnt_q      <= '0;
      addr_q     <= '0;
      pu_en_q    <= 1'b0;
      vld_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      pu_en_q    <= issue;
      vld_q      <= vld_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  // FIFO storage; contents are only meaningful under the count
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.pu_result;
    end
  end

  assign bus.rd_en     = issue;
  assign bus.rd_addr   = issue ? cnt_q : addr_q;
  assign bus.pu_en     = pu_en_q;
  assign bus.out_valid = (fifo_cnt_q != '0);
  // Masked so stale storage never shows while the FIFO is empty
  assign bus.out_data  = (fifo_cnt_q != '0) ? mem_q[rd_ptr_q] : 5'd0;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);

  a_fifo_no_overflow : assert property (
    @(posedge clk) disable iff (rst) fifo_cnt_q <= CNT_W'(FIFO_DEPTH)
  );

endmodule
